toggle_debounce: RTL and testbench

Front-end conditioner for the traffic-light controller's `toggle` input. It takes a raw, asynchronous, bouncing pushbutton and synchronises it to `clk`, then debounces it with a clock-enable-qualified counter. Each accepted press becomes exactly one single-cycle `toggle` pulse. A post-release holdoff window rate-limits presses so the downstream light sequencer is never toggled faster than intended.

---
 rtl/toggle_debounce_pkg.sv | 14 +
 rtl/sync_2ff.sv | 24 ++
 rtl/toggle_debounce.sv | 106 ++++++++++
 tb/tb_toggle_debounce.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/toggle_debounce_pkg.sv
// Shared types and widths for the toggle input conditioner.
package toggle_debounce_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    HELD,
    DISARM,
    HOLDOFF
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs; cleared by rst_n.
module sync_2ff #(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] meta_p0;

  // stage 0: metastability capture, stage 1: settled output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= '0;
      q       <= '0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/toggle_debounce.sv
// Synchronises and debounces a raw pushbutton into one toggle pulse per press,
// with a post-release holdoff that rate-limits presses.
module toggle_debounce
  import toggle_debounce_pkg::*;
#(
  parameter logic [CNT_W-1:0] DEBOUNCE_TIME = 32'd4,
  parameter logic [CNT_W-1:0] HOLDOFF_TIME  = 32'd8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic button,
  output logic toggle,
  output logic pressed,
  output logic busy
);

  logic             btn_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             toggle_nxt, pressed_nxt, busy_nxt;

  sync_2ff #(.DATA_W(1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (button),
    .q     (btn_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      toggle  <= 1'b0;
      pressed <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      toggle  <= toggle_nxt;
      pressed <= pressed_nxt;
      busy    <= busy_nxt;
    end
  end

  // toggle defaults low every clk so the pulse never outlives one cycle, even with ce=0
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    toggle_nxt  = 1'b0;
    pressed_nxt = pressed;
    busy_nxt    = busy;
    if (ce) begin
      case (state)
        IDLE: begin
          if (btn_s) begin
            state_nxt = ARM;
            cnt_nxt   = '0;
          end
        end
        ARM: begin
          if (!btn_s) begin
            state_nxt = IDLE;
          end else if (cnt == DEBOUNCE_TIME - 32'd1) begin
            state_nxt   = HELD;
            toggle_nxt  = 1'b1;
            pressed_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 32'd1;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state_nxt = DISARM;
            cnt_nxt   = '0;
          end
        end
        DISARM: begin
          if (btn_s) begin
            state_nxt = HELD;
          end else if (cnt == DEBOUNCE_TIME - 32'd1) begin
            state_nxt   = HOLDOFF;
            cnt_nxt     = '0;
            pressed_nxt = 1'b0;
            busy_nxt    = 1'b1;
          end else begin
            cnt_nxt = cnt + 32'd1;
          end
        end
        HOLDOFF: begin
          if (cnt == HOLDOFF_TIME - 32'd1) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end else begin
            cnt_nxt = cnt + 32'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_debounce.sv
// Directed bench for toggle_debounce: a run-length model of the debouncer is
// compared every cycle, and literal edge numbers pin the model.
module tb_toggle_debounce;

  localparam int DT = 4;
  localparam int HT = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ce = 1'b1;
  logic button = 1'b0;
  logic toggle, pressed, busy;

  toggle_debounce #(
    .DEBOUNCE_TIME (32'd4),
    .HOLDOFF_TIME  (32'd8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce      (ce),
    .button  (button),
    .toggle  (toggle),
    .pressed (pressed),
    .busy    (busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at edge %0d: got %b, expected %b", name, cyc, act, exp);
  endtask

  // Model: a press or release is accepted after DT+1 consecutive ce samples
  // of the synchronised button disagreeing with the debounced level; a release
  // then starts HT ce-cycles during which samples are ignored.
  logic m_s1 = 1'b0, m_s2 = 1'b0, m_bs = 1'b0;
  logic m_pressed = 1'b0, m_toggle = 1'b0;
  int   m_run = 0, m_hold = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_pressed = 1'b0; m_toggle = 1'b0;
      m_run = 0; m_hold = 0;
    end else begin
      m_bs = m_s2;
      m_s2 = m_s1;
      m_s1 = button;
      m_toggle = 1'b0;
      if (ce) begin
        if (m_hold > 0) m_hold--;
        else if (m_bs == m_pressed) m_run = 0;
        else begin
          m_run++;
          if (m_run == DT + 1) begin
            m_run = 0;
            m_pressed = ~m_pressed;
            if (m_pressed) m_toggle = 1'b1;
            else m_hold = HT;
          end
        end
      end
    end
  end

  int tog_n = 0;
  int tog_edge [8];

  always @(negedge clk) begin
    chk("toggle_model", toggle, m_toggle);
    chk("pressed_model", pressed, m_pressed);
    chk("busy_model", busy, logic'(m_hold > 0));
    if (toggle === 1'b1) begin
      if (tog_n < 8) tog_edge[tog_n] = cyc;
      tog_n++;
    end
  end

  // returns at the falling edge following rising edge n
  task automatic at_edge(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  int exp_edges [5] = '{16, 66, 110, 160, 223};

  initial begin
    #1 rst_n = 1'b0;
    #4;
    chk("reset_toggle", toggle, 1'b0);
    chk("reset_pressed", pressed, 1'b0);
    chk("reset_busy", busy, 1'b0);
    at_edge(2);
    rst_n = 1'b1;

    // clean press held 30 cycles
    at_edge(9);  button = 1'b1;
    at_edge(15); chk("s1_toggle_early", toggle, 1'b0);
    at_edge(16); chk("s1_toggle", toggle, 1'b1); chk("s1_pressed", pressed, 1'b1);
    at_edge(17); chk("s1_toggle_width", toggle, 1'b0);
    at_edge(39); button = 1'b0;

    // release, holdoff, re-press during holdoff then after it
    at_edge(45); chk("s4_busy_pre", busy, 1'b0); chk("s4_pressed_pre", pressed, 1'b1);
    at_edge(46); chk("s4_busy_rise", busy, 1'b1); chk("s4_pressed_fall", pressed, 1'b0);
    at_edge(47); button = 1'b1;
    at_edge(51); button = 1'b0;
    at_edge(53); chk("s4_busy_last", busy, 1'b1);
    at_edge(54); chk("s4_busy_fall", busy, 1'b0);
    at_edge(59); button = 1'b1;
    at_edge(79); button = 1'b0;

    // bounce 1,0,1,0 then held
    at_edge(99);  button = 1'b1;
    at_edge(100); button = 1'b0;
    at_edge(101); button = 1'b1;
    at_edge(102); button = 1'b0;
    at_edge(103); button = 1'b1;
    at_edge(119); button = 1'b0;

    // three-cycle glitch
    at_edge(139); button = 1'b1;
    at_edge(142); button = 1'b0;
    at_edge(146); chk("s3_pressed", pressed, 1'b0);

    // ce alternating with a clean press and release
    for (int e = 149; e <= 199; e++) begin
      at_edge(e);
      ce = ((e - 149) % 2 == 0);
      if (e == 149) button = 1'b1;
      if (e == 169) button = 1'b0;
      if (e == 160) chk("s5_toggle", toggle, 1'b1);
      if (e == 161) chk("s5_toggle_width", toggle, 1'b0);
    end
    ce = 1'b1;

    // reset after two ARM counts with the button held
    at_edge(209); button = 1'b1;
    at_edge(214);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_toggle", toggle, 1'b0);
    chk("s6_rst_pressed", pressed, 1'b0);
    chk("s6_rst_busy", busy, 1'b0);
    at_edge(216); rst_n = 1'b1;
    at_edge(223); chk("s6_toggle", toggle, 1'b1);
    at_edge(239); button = 1'b0;
    at_edge(260);

    checks++;
    if (tog_n == 5) passes++;
    else $display("FAIL toggle_count: got %0d, expected 5", tog_n);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i < tog_n && tog_edge[i] == exp_edges[i]) passes++;
      else $display("FAIL toggle_edge[%0d]: got %0d, expected %0d", i,
                    (i < tog_n) ? tog_edge[i] : -1, exp_edges[i]);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
